// File: rtl/reset_seq_gen_if.sv
// Bundles the UART trigger inputs, reset requests and reset outputs of reset_seq_gen.
// The master side drives the requests and observes the resets.
interface reset_seq_gen_if #(
    parameter int NCH = 2
);
    logic           bu_rx_data_rdy;
    logic [7:0]     bu_rx_data;
    logic           ext_rst;
    logic           tb_sim_rst;
    logic [NCH-1:0] rst;
    logic           rst_done;
    logic           rst_busy;
    logic [1:0]     rst_cause;

    modport master (
        output bu_rx_data_rdy, bu_rx_data, ext_rst, tb_sim_rst,
        input  rst, rst_done, rst_busy, rst_cause
    );

    modport slave (
        input  bu_rx_data_rdy, bu_rx_data, ext_rst, tb_sim_rst,
        output rst, rst_done, rst_busy, rst_cause
    );
endinterface

// File: rtl/reset_seq_gen.sv
// Multi-channel reset generator: power-on, UART key run, external and simulation triggers,
// programmable hold time and staggered per-channel release.
module reset_seq_gen #(
    parameter int         NCH         = 2,
    parameter int         HOLD_CYCLES = 16,
    parameter int         STAGGER     = 4,
    parameter logic [7:0] TRIG_CHAR   = 8'h1b,
    parameter int         TRIG_COUNT  = 1
) (
    input  logic         clk,
    input  logic         resetq,
    reset_seq_gen_if.slave bus
);
    localparam int FINAL = HOLD_CYCLES + (NCH - 1) * STAGGER;
    localparam int CNT_W = $clog2(FINAL + 1);
    localparam int MW    = $clog2(TRIG_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FINAL);
    localparam logic [CNT_W-1:0] CNT_HOLD   = CNT_W'(HOLD_CYCLES);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(TRIG_COUNT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_STAGGER} state_t;

    state_t         state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [MW-1:0]  match_reg, match_next;
    logic [NCH-1:0] rst_reg, rst_next, rel_hit;
    logic           done_reg, done_next;
    logic           busy_reg, busy_next;
    logic [1:0]     cause_reg, cause_next;
    logic           key_fire, req, fire;

    assign req     = bus.ext_rst | bus.tb_sim_rst;
    assign fire    = key_fire | req;
    assign cnt_inc = (cnt_reg == CNT_LAST) ? cnt_reg : cnt_reg + CNT_W'(1);

    // Channel gi releases when the incremented count reaches its own threshold.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rel
            localparam int REL = HOLD_CYCLES + gi * STAGGER;
            assign rel_hit[gi] = (cnt_inc == CNT_W'(REL));
        end
    endgenerate

    always_comb begin
        key_fire   = 1'b0;
        match_next = match_reg;
        if (bus.bu_rx_data_rdy) begin
            if (bus.bu_rx_data == TRIG_CHAR) begin
                if (match_reg == MATCH_LAST) begin
                    key_fire   = 1'b1;
                    match_next = '0;
                end else begin
                    match_next = match_reg + MW'(1);
                end
            end else begin
                match_next = '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rst_next   = rst_reg;
        done_next  = 1'b0;
        cause_next = cause_reg;
        if (fire) begin
            state_next = ST_ASSERT;
            cnt_next   = '0;
            rst_next   = '1;
            cause_next = req ? 2'b10 : 2'b01;
        end else begin
            case (state_reg)
                ST_ASSERT, ST_STAGGER: begin
                    cnt_next = cnt_inc;
                    rst_next = rst_reg & ~rel_hit;
                    if (rst_reg[NCH-1] && rel_hit[NCH-1]) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (cnt_inc >= CNT_HOLD) begin
                        state_next = ST_STAGGER;
                    end else begin
                        state_next = ST_ASSERT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        busy_next = |rst_next;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_reg <= ST_ASSERT;
            cnt_reg   <= '0;
            match_reg <= '0;
            rst_reg   <= '1;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            cause_reg <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            match_reg <= match_next;
            rst_reg   <= rst_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            cause_reg <= cause_next;
        end
    end

    assign bus.rst       = rst_reg;
    assign bus.rst_done  = done_reg;
    assign bus.rst_busy  = busy_reg;
    assign bus.rst_cause = cause_reg;
endmodule

// File: tb/tb_reset_seq_gen.sv
// Scoreboard bench for reset_seq_gen: stimulus queues expected output events, monitors
// compare them whenever a DUT's rst, rst_cause or rst_done changes.
module tb_reset_seq_gen;
    logic clk = 1'b0;
    logic resetq = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [1:0] rst;
        logic       done;
        logic [1:0] cause;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    reset_seq_gen_if #(.NCH(2)) bus_a ();
    reset_seq_gen_if #(.NCH(1)) bus_b ();

    reset_seq_gen #(.NCH(2), .HOLD_CYCLES(16), .STAGGER(4), .TRIG_CHAR(8'h1b), .TRIG_COUNT(2))
        dut_a (.clk(clk), .resetq(resetq), .bus(bus_a.slave));
    reset_seq_gen #(.NCH(1), .HOLD_CYCLES(1), .STAGGER(0), .TRIG_CHAR(8'h1b), .TRIG_COUNT(1))
        dut_b (.clk(clk), .resetq(resetq), .bus(bus_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_a(int c, logic [1:0] r, logic d, logic [1:0] ca);
        ev_t e;
        e.cyc = c; e.rst = r; e.done = d; e.cause = ca;
        q_a.push_back(e);
    endfunction

    function automatic void push_b(int c, logic [1:0] r, logic d, logic [1:0] ca);
        ev_t e;
        e.cyc = c; e.rst = r; e.done = d; e.cause = ca;
        q_b.push_back(e);
    endfunction

    function automatic void check_ev(string name, ref ev_t q[$], input logic [1:0] r,
                                     input logic d, input logic b, input logic [1:0] ca);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event cyc=%0d rst=%b done=%b cause=%b", name, cyc, r, d, ca);
        end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.rst != r || e.done != d || e.cause != ca || b != (|e.rst)) begin
                errors++;
                $display("FAIL %s got cyc=%0d rst=%b done=%b cause=%b busy=%b expected cyc=%0d rst=%b done=%b cause=%b busy=%b",
                         name, cyc, r, d, ca, b, e.cyc, e.rst, e.done, e.cause, |e.rst);
            end else begin
                $display("ok   %s cyc=%0d rst=%b done=%b cause=%b", name, cyc, r, d, ca);
            end
        end
    endfunction

    logic [1:0] prev_a_rst = 2'b11, prev_a_cause = 2'b00;
    logic       prev_b_rst = 1'b1;
    logic [1:0] prev_b_cause = 2'b00;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_a.rst != prev_a_rst || bus_a.rst_cause != prev_a_cause || bus_a.rst_done)
                check_ev("dut_a", q_a, bus_a.rst, bus_a.rst_done, bus_a.rst_busy, bus_a.rst_cause);
            if (bus_b.rst != prev_b_rst || bus_b.rst_cause != prev_b_cause || bus_b.rst_done)
                check_ev("dut_b", q_b, {1'b0, bus_b.rst}, bus_b.rst_done, bus_b.rst_busy, bus_b.rst_cause);
            prev_a_rst   = bus_a.rst;
            prev_a_cause = bus_a.rst_cause;
            prev_b_rst   = bus_b.rst;
            prev_b_cause = bus_b.rst_cause;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Strobes one byte into dut_a (optionally with ext_rst); t is the sampling edge.
    task automatic send_a(input logic [7:0] b, input logic with_ext, output int t);
        t = cyc + 1;
        bus_a.bu_rx_data_rdy = 1'b1;
        bus_a.bu_rx_data     = b;
        bus_a.ext_rst        = with_ext;
        tick(1);
        bus_a.bu_rx_data_rdy = 1'b0;
        bus_a.bu_rx_data     = 8'h00;
        bus_a.ext_rst        = 1'b0;
    endtask

    initial begin
        int t, r, h;
        bus_a.bu_rx_data_rdy = 1'b0; bus_a.bu_rx_data = 8'h00;
        bus_a.ext_rst = 1'b0; bus_a.tb_sim_rst = 1'b0;
        bus_b.bu_rx_data_rdy = 1'b0; bus_b.bu_rx_data = 8'h00;
        bus_b.ext_rst = 1'b0; bus_b.tb_sim_rst = 1'b0;

        // Power-on: resetq low for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check_val("por_rst", int'(bus_a.rst), 3);
            check_val("por_busy", int'(bus_a.rst_busy), 1);
            check_val("por_done", int'(bus_a.rst_done), 0);
            check_val("por_cause", int'(bus_a.rst_cause), 0);
        end
        mon_en = 1'b1;
        r = cyc;
        push_a(r + 16, 2'b10, 1'b0, 2'b00);
        push_a(r + 20, 2'b00, 1'b1, 2'b00);
        push_b(r + 1,  2'b00, 1'b1, 2'b00);
        resetq = 1'b1;
        tick(25);

        // Key run with TRIG_COUNT=2: 1b,41,1b does not fire; the next 1b does.
        send_a(8'h1b, 1'b0, t); tick(5);
        send_a(8'h41, 1'b0, t); tick(5);
        send_a(8'h1b, 1'b0, t); tick(5);
        send_a(8'h1b, 1'b0, t);
        push_a(t,      2'b11, 1'b0, 2'b01);
        push_a(t + 16, 2'b10, 1'b0, 2'b01);
        // Retrigger by ext_rst at T+18 after rst[0] released; aborted sequence gives no done.
        push_a(t + 18, 2'b11, 1'b0, 2'b10);
        push_a(t + 34, 2'b10, 1'b0, 2'b10);
        push_a(t + 38, 2'b00, 1'b1, 2'b10);
        tick(17);
        bus_a.ext_rst = 1'b1;
        tick(1);
        bus_a.ext_rst = 1'b0;
        tick(45);

        // Hold: tb_sim_rst high for 10 sampled edges.
        push_a(cyc + 1, 2'b11, 1'b0, 2'b10);
        h = cyc + 10;
        push_a(h + 16, 2'b10, 1'b0, 2'b10);
        push_a(h + 20, 2'b00, 1'b1, 2'b10);
        bus_a.tb_sim_rst = 1'b1;
        tick(10);
        bus_a.tb_sim_rst = 1'b0;
        tick(25);

        // Simultaneous key fire and ext_rst, then async resetq mid-sequence.
        send_a(8'h1b, 1'b0, t); tick(3);
        send_a(8'h1b, 1'b1, t);
        push_a(t, 2'b11, 1'b0, 2'b10);
        tick(1);
        send_a(8'h1b, 1'b0, r);
        tick(3);
        push_a(cyc, 2'b11, 1'b0, 2'b00);
        push_b(cyc, 2'b01, 1'b0, 2'b00);
        resetq = 1'b0;
        #1;
        check_val("async_rst", int'(bus_a.rst), 3);
        check_val("async_cause", int'(bus_a.rst_cause), 0);
        check_val("async_busy", int'(bus_a.rst_busy), 1);
        check_val("async_rst_b", int'(bus_b.rst), 1);
        tick(2);
        r = cyc;
        push_a(r + 16, 2'b10, 1'b0, 2'b00);
        push_a(r + 20, 2'b00, 1'b1, 2'b00);
        push_b(r + 1,  2'b00, 1'b1, 2'b00);
        resetq = 1'b1;
        tick(22);
        // Match was cleared by resetq, so a single 1b must not fire; the second one does.
        send_a(8'h1b, 1'b0, t); tick(5);
        send_a(8'h1b, 1'b0, t);
        push_a(t,      2'b11, 1'b0, 2'b01);
        push_a(t + 16, 2'b10, 1'b0, 2'b01);
        push_a(t + 20, 2'b00, 1'b1, 2'b01);
        tick(25);

        // Single channel, HOLD=1, STAGGER=0: one-cycle reset pulse.
        t = cyc + 1;
        push_b(t,     2'b01, 1'b0, 2'b01);
        push_b(t + 1, 2'b00, 1'b1, 2'b01);
        bus_b.bu_rx_data_rdy = 1'b1;
        bus_b.bu_rx_data     = 8'h1b;
        tick(1);
        bus_b.bu_rx_data_rdy = 1'b0;
        bus_b.bu_rx_data     = 8'h00;
        tick(5);

        check_val("q_a_left", q_a.size(), 0);
        check_val("q_b_left", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
